ls_unit: RTL and testbench
==========================

Name: ls_unit

Overview:
Load/store execution unit downstream of the scoreboard/register issue stage. It accepts one memory instruction per issue broadcast (exe_dest=1) and performs the access through the memory controller's LS port. Sub-word stores use read-modify-write on the 32-bit memory. It returns the result, or a completion for stores, on the writeback bus, which frees the scoreboard entry and updates rd.

Parameters:
ADDR_WIDTH, 32, memory address width
DATA_WIDTH, 32, data/register value width
SB_SIZE_WIDTH, 4, scoreboard entry index width
REG_WIDTH, 5, register index width

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  synchronous, active-high reset
sb_vacant  out  1  high when unit can accept an instruction (state IDLE)
exe_valid  in  1  issue broadcast valid
exe_dest  in  1  1 = LS target; unit ignores broadcasts with 0
exe_pos  in  SB_SIZE_WIDTH  scoreboard entry index
exe_opt  in  7  opcode: 0000011 load, 0100011 store
exe_funct  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
exe_rd  in  REG_WIDTH  destination register
exe_imm  in  DATA_WIDTH  sign-extended offset
exe_rs1  in  DATA_WIDTH  base value
exe_rs2  in  DATA_WIDTH  store data
mc_valid  out  1  memory request valid
mc_we  out  1  1 = write
mc_addr  out  ADDR_WIDTH  word-aligned address
mc_src  out  DATA_WIDTH  write data
mc_done  in  1  one-cycle completion pulse
mc_data  in  DATA_WIDTH  read data, valid with mc_done
wb_valid  out  1  writeback valid
wb_ready  in  1  writeback bus grant
wb_pos  out  SB_SIZE_WIDTH  entry being completed
wb_rd  out  REG_WIDTH  rd for loads, 0 for stores
wb_value  out  DATA_WIDTH  load result, 0 for stores

Behaviour:
- Reset: state IDLE; sb_vacant=1; mc_valid, mc_we, wb_valid=0; mc_addr, mc_src, wb_pos, wb_rd, wb_value=0.
- Accept when exe_valid & exe_dest & sb_vacant. Latch pos, opt, funct, rd and rs2. Set ea = exe_rs1 + exe_imm (mod 2^32). Set off = ea[1:0]. mc_addr = {ea[31:2],2'b00}.
- States: IDLE, LD, RMW_RD, ST, WB. All outputs are registered.
- IDLE→LD on a load. IDLE→ST on SW, or on SB/SH when ea[17:16]==2'b11 (I/O). IDLE→RMW_RD on SB/SH otherwise. mc_valid rises the cycle after acceptance.
- mc_valid, mc_we, mc_addr and mc_src are held stable until the cycle mc_done=1. mc_valid drops on the following edge unless the next state issues another request.
- LD + mc_done: extract the field from mc_data. B/BU take byte lane off. H/HU take halfword lane off[1]; off[0] is ignored. W ignores off. B/H sign-extend; BU/HU zero-extend. Latch into wb_value and go to WB.
- RMW_RD + mc_done: merge rs2[7:0] into byte lane off, or rs2[15:0] into halfword lane off[1], of mc_data. The result becomes mc_src. Go to ST with mc_we=1; the new request starts the next cycle, with one idle cycle of mc_valid low between requests.
- ST (mc_we=1): SW writes rs2. I/O SB/SH writes rs2 zero-extended from the byte/halfword. mc_done→WB with wb_rd=0, wb_value=0.
- WB: wb_valid=1 with stable pos/rd/value until an edge where wb_ready=1; then →IDLE, wb_valid=0.
- Latency with wb_ready held 1: load or SW has mc_valid at accept+1. If mc_done arrives on cycle D, wb_valid is high at D+1. SB/SH non-I/O pays two memory round trips.
- sb_vacant=0 in every state except IDLE. exe broadcasts for LS during busy are a protocol violation and are ignored.
- Unsupported opt/funct (e.g. store funct 1xx): go straight to WB with wb_rd=0, wb_value=0, and issue no memory request.
- Reset mid-operation returns to IDLE on that edge. A later mc_done for the aborted request is ignored in IDLE.
- mc_done while mc_valid=0 is ignored.

Test Plan:
- rs1=0x1000, imm=4, LW, mem[0x1004]=0xDEADBEEF → mc_addr=0x1004, we=0; wb_valid with wb_rd=rd, wb_value=0xDEADBEEF, wb_pos echoed.
- LB ea=0x1007, word=0x80112233 → 0xFFFFFF80; LBU same → 0x00000080; LH ea=0x1006 → 0xFFFF8011.
- SB ea=0x2001, rs2=0xAB, word=0x11223344 → read of 0x2000, then write 0x1122AB44 to 0x2000; wb_rd=0.
- SB ea=0x30000, rs2=0x41 → single write to 0x30000 with src=0x00000041 and no read.
- Load completes with wb_ready=0 for 5 cycles → wb_valid and its data held stable; sb_vacant=0 until the edge with wb_ready=1.
- rst asserted while in RMW_RD, then stray mc_done → outputs at reset values next cycle, no write issued, sb_vacant=1.

Source files
------------

// File: rtl/ls_unit.sv
// ls_unit: load/store execution unit behind the scoreboard issue stage.
// Takes one memory instruction per issue broadcast, performs it through the
// memory controller LS port, and reports the result (or a store completion)
// on the writeback bus.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   sb_vacant             unit idle and able to accept an instruction
//   exe_*                 issue broadcast (valid, dest, pos, opt, funct, rd,
//                         imm, rs1, rs2)
//   mc_valid/we/addr/src  memory request (word-aligned), held until mc_done
//   mc_done, mc_data      memory completion pulse and read data
//   wb_valid/pos/rd/value writeback result, held until wb_ready
module ls_unit #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SB_SIZE_WIDTH = 4,
  parameter int REG_WIDTH     = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     sb_vacant,
  input  logic                     exe_valid,
  input  logic                     exe_dest,
  input  logic [SB_SIZE_WIDTH-1:0] exe_pos,
  input  logic [6:0]               exe_opt,
  input  logic [2:0]               exe_funct,
  input  logic [REG_WIDTH-1:0]     exe_rd,
  input  logic [DATA_WIDTH-1:0]    exe_imm,
  input  logic [DATA_WIDTH-1:0]    exe_rs1,
  input  logic [DATA_WIDTH-1:0]    exe_rs2,
  output logic                     mc_valid,
  output logic                     mc_we,
  output logic [ADDR_WIDTH-1:0]    mc_addr,
  output logic [DATA_WIDTH-1:0]    mc_src,
  input  logic                     mc_done,
  input  logic [DATA_WIDTH-1:0]    mc_data,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [SB_SIZE_WIDTH-1:0] wb_pos,
  output logic [REG_WIDTH-1:0]     wb_rd,
  output logic [DATA_WIDTH-1:0]    wb_value
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD,
    S_RMW_RD,
    S_ST,
    S_WB
  } state_e;

  state_e                   state_q, state_d;
  logic [SB_SIZE_WIDTH-1:0] pos_q, pos_d;
  logic [2:0]               funct_q, funct_d;
  logic [REG_WIDTH-1:0]     rd_q, rd_d;
  logic [DATA_WIDTH-1:0]    rs2_q, rs2_d;
  logic [1:0]               off_q, off_d;

  logic                     sb_vacant_q, sb_vacant_d;
  logic                     mc_valid_q, mc_valid_d;
  logic                     mc_we_q, mc_we_d;
  logic [ADDR_WIDTH-1:0]    mc_addr_q, mc_addr_d;
  logic [DATA_WIDTH-1:0]    mc_src_q, mc_src_d;
  logic                     wb_valid_q, wb_valid_d;
  logic [SB_SIZE_WIDTH-1:0] wb_pos_q, wb_pos_d;
  logic [REG_WIDTH-1:0]     wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0]    wb_value_q, wb_value_d;

  // Issue-side decode
  logic [DATA_WIDTH-1:0] ea;
  logic                  ld_ok;
  logic                  st_ok;
  logic                  io_space;

  assign ea       = exe_rs1 + exe_imm;
  assign io_space = (ea[17:16] == 2'b11);
  assign ld_ok    = (exe_opt == OPC_LOAD) &&
                    (exe_funct inside {F_B, F_H, F_W, F_BU, F_HU});
  assign st_ok    = (exe_opt == OPC_STORE) &&
                    (exe_funct inside {F_B, F_H, F_W});

  // Memory-side lane handling, driven by the latched offset
  logic [4:0]            byte_sh;
  logic [4:0]            half_sh;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_result;
  logic [DATA_WIDTH-1:0] byte_mask;
  logic [DATA_WIDTH-1:0] half_mask;
  logic [DATA_WIDTH-1:0] rmw_word;
  logic [DATA_WIDTH-1:0] io_src;

  assign byte_sh   = {off_q, 3'b000};
  assign half_sh   = {off_q[1], 4'b0000};
  assign ld_byte   = 8'(mc_data >> byte_sh);
  assign ld_half   = 16'(mc_data >> half_sh);
  assign byte_mask = DATA_WIDTH'(8'hFF) << byte_sh;
  assign half_mask = DATA_WIDTH'(16'hFFFF) << half_sh;

  always_comb begin
    ld_result = mc_data;
    case (funct_q)
      F_B:     ld_result = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      F_BU:    ld_result = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      F_H:     ld_result = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      F_HU:    ld_result = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_result = mc_data;
    endcase
  end

  // Only SB/SH ever reach the read-modify-write path, so funct[0] picks the lane width.
  always_comb begin
    if (funct_q[0] == 1'b0) begin
      rmw_word = (mc_data & ~byte_mask) | (DATA_WIDTH'(rs2_q[7:0]) << byte_sh);
    end else begin
      rmw_word = (mc_data & ~half_mask) | (DATA_WIDTH'(rs2_q[15:0]) << half_sh);
    end
  end

  always_comb begin
    case (exe_funct)
      F_B:     io_src = DATA_WIDTH'(exe_rs2[7:0]);
      F_H:     io_src = DATA_WIDTH'(exe_rs2[15:0]);
      default: io_src = exe_rs2;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    funct_d    = funct_q;
    rd_d       = rd_q;
    rs2_d      = rs2_q;
    off_d      = off_q;
    mc_valid_d = mc_valid_q;
    mc_we_d    = mc_we_q;
    mc_addr_d  = mc_addr_q;
    mc_src_d   = mc_src_q;
    wb_valid_d = wb_valid_q;
    wb_pos_d   = wb_pos_q;
    wb_rd_d    = wb_rd_q;
    wb_value_d = wb_value_q;

    unique case (state_q)
      S_IDLE: begin
        if (exe_valid && exe_dest) begin
          pos_d   = exe_pos;
          funct_d = exe_funct;
          rd_d    = exe_rd;
          rs2_d   = exe_rs2;
          off_d   = ea[1:0];
          if (ld_ok) begin
            state_d    = S_LD;
            mc_valid_d = 1'b1;
            mc_we_d    = 1'b0;
            mc_addr_d  = {ea[ADDR_WIDTH-1:2], 2'b00};
          end else if (st_ok) begin
            mc_valid_d = 1'b1;
            mc_addr_d  = {ea[ADDR_WIDTH-1:2], 2'b00};
            if (exe_funct == F_W || io_space) begin
              state_d  = S_ST;
              mc_we_d  = 1'b1;
              mc_src_d = io_src;
            end else begin
              state_d  = S_RMW_RD;
              mc_we_d  = 1'b0;
            end
          end else begin
            // Unsupported encoding: complete immediately without touching memory.
            state_d    = S_WB;
            wb_valid_d = 1'b1;
            wb_pos_d   = exe_pos;
            wb_rd_d    = '0;
            wb_value_d = '0;
          end
        end
      end

      S_LD: begin
        if (mc_valid_q && mc_done) begin
          state_d    = S_WB;
          mc_valid_d = 1'b0;
          wb_valid_d = 1'b1;
          wb_pos_d   = pos_q;
          wb_rd_d    = rd_q;
          wb_value_d = ld_result;
        end
      end

      S_RMW_RD: begin
        // The write request is raised from S_ST, leaving one idle cycle between requests.
        if (mc_valid_q && mc_done) begin
          state_d    = S_ST;
          mc_valid_d = 1'b0;
          mc_we_d    = 1'b1;
          mc_src_d   = rmw_word;
        end
      end

      S_ST: begin
        if (mc_valid_q && mc_done) begin
          state_d    = S_WB;
          mc_valid_d = 1'b0;
          mc_we_d    = 1'b0;
          wb_valid_d = 1'b1;
          wb_pos_d   = pos_q;
          wb_rd_d    = '0;
          wb_value_d = '0;
        end else begin
          mc_valid_d = 1'b1;
        end
      end

      S_WB: begin
        if (wb_ready) begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b0;
        end
      end

      default: begin
        state_d    = S_IDLE;
        mc_valid_d = 1'b0;
        wb_valid_d = 1'b0;
      end
    endcase

    sb_vacant_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pos_q       <= '0;
      funct_q     <= '0;
      rd_q        <= '0;
      rs2_q       <= '0;
      off_q       <= '0;
      sb_vacant_q <= 1'b1;
      mc_valid_q  <= 1'b0;
      mc_we_q     <= 1'b0;
      mc_addr_q   <= '0;
      mc_src_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_pos_q    <= '0;
      wb_rd_q     <= '0;
      wb_value_q  <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      funct_q     <= funct_d;
      rd_q        <= rd_d;
      rs2_q       <= rs2_d;
      off_q       <= off_d;
      sb_vacant_q <= sb_vacant_d;
      mc_valid_q  <= mc_valid_d;
      mc_we_q     <= mc_we_d;
      mc_addr_q   <= mc_addr_d;
      mc_src_q    <= mc_src_d;
      wb_valid_q  <= wb_valid_d;
      wb_pos_q    <= wb_pos_d;
      wb_rd_q     <= wb_rd_d;
      wb_value_q  <= wb_value_d;
    end
  end

  assign sb_vacant = sb_vacant_q;
  assign mc_valid  = mc_valid_q;
  assign mc_we     = mc_we_q;
  assign mc_addr   = mc_addr_q;
  assign mc_src    = mc_src_q;
  assign wb_valid  = wb_valid_q;
  assign wb_pos    = wb_pos_q;
  assign wb_rd     = wb_rd_q;
  assign wb_value  = wb_value_q;

endmodule

// File: tb/tb_ls_unit.sv
// tb_ls_unit: self-checking bench for ls_unit. A memory responder with random
// latency serves the LS port from a sparse word memory; each instruction's
// expected requests and writeback are computed from byte/halfword arithmetic
// on that memory before the instruction is issued.
module tb_ls_unit;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        sb_vacant;
  logic        exe_valid, exe_dest;
  logic [3:0]  exe_pos;
  logic [6:0]  exe_opt;
  logic [2:0]  exe_funct;
  logic [4:0]  exe_rd;
  logic [31:0] exe_imm, exe_rs1, exe_rs2;
  logic        mc_valid, mc_we;
  logic [31:0] mc_addr, mc_src;
  logic        mc_done;
  logic [31:0] mc_data;
  logic        wb_valid, wb_ready;
  logic [3:0]  wb_pos;
  logic [4:0]  wb_rd;
  logic [31:0] wb_value;

  ls_unit #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .SB_SIZE_WIDTH (4),
    .REG_WIDTH     (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sb_vacant (sb_vacant),
    .exe_valid (exe_valid),
    .exe_dest  (exe_dest),
    .exe_pos   (exe_pos),
    .exe_opt   (exe_opt),
    .exe_funct (exe_funct),
    .exe_rd    (exe_rd),
    .exe_imm   (exe_imm),
    .exe_rs1   (exe_rs1),
    .exe_rs2   (exe_rs2),
    .mc_valid  (mc_valid),
    .mc_we     (mc_we),
    .mc_addr   (mc_addr),
    .mc_src    (mc_src),
    .mc_done   (mc_done),
    .mc_data   (mc_data),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_pos    (wb_pos),
    .wb_rd     (wb_rd),
    .wb_value  (wb_value)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Sparse memory; untouched words read as an address hash.
  bit [31:0] mem [bit [31:0]];
  function automatic bit [31:0] mem_rd(input bit [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  typedef struct {
    bit        we;
    bit [31:0] addr;
    bit [31:0] src;
  } req_t;
  req_t log_q[$];

  bit resp_en   = 1'b1;
  bit stray_req = 1'b0;
  int last_done_cyc = 0;

  // Memory responder: request sampled on negedge, done after 0..3 extra cycles.
  initial begin
    bit        busy = 1'b0;
    int        cnt  = 0;
    bit        w0   = 1'b0;
    bit [31:0] a0   = '0;
    bit [31:0] s0   = '0;
    mc_done = 1'b0;
    mc_data = '0;
    forever begin
      @(negedge clk);
      mc_done = 1'b0;
      if (stray_req) begin
        stray_req = 1'b0;
        mc_done   = 1'b1;
        mc_data   = 32'hBAD0BAD0;
      end
      if (!busy && resp_en && mc_valid && !rst) begin
        busy = 1'b1;
        cnt  = $urandom_range(0, 3);
        w0   = mc_we;
        a0   = mc_addr;
        s0   = mc_src;
      end
      if (busy) begin
        check("mc_hold_valid", {31'b0, mc_valid}, 32'd1);
        check("mc_hold_we", {31'b0, mc_we}, {31'b0, w0});
        check("mc_hold_addr", mc_addr, a0);
        if (w0) check("mc_hold_src", mc_src, s0);
        if (cnt == 0) begin
          busy = 1'b0;
          mc_done = 1'b1;
          last_done_cyc = cyc;
          if (w0) mem[a0] = s0;
          else mc_data = mem_rd(a0);
          log_q.push_back('{we: w0, addr: a0, src: (w0 ? s0 : 32'h0)});
        end else begin
          cnt--;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one instruction (called at a negedge) and check everything it produces.
  task automatic run_op(input bit [6:0] opt, input bit [2:0] f, input bit [31:0] rs1,
                        input bit [31:0] imm, input bit [31:0] rs2, input bit [4:0] rd,
                        input bit [3:0] pos, input int hold, input bit junk);
    bit [31:0] ea;
    bit [31:0] wa;
    int        off;
    bit [31:0] word;
    bit [31:0] merged;
    bit [7:0]  b;
    bit [15:0] h;
    bit [4:0]  e_rd;
    bit [31:0] e_val;
    bit        is_ld, is_st, memop;
    req_t      exp_q[$];
    int        t;

    ea    = rs1 + imm;
    wa    = {ea[31:2], 2'b00};
    off   = int'(ea[1:0]);
    word  = mem_rd(wa);
    b     = word[8*off +: 8];
    h     = word[16*(off/2) +: 16];
    e_rd  = '0;
    e_val = '0;
    is_ld = (opt == LOAD)  && (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    is_st = (opt == STORE) && (f inside {3'd0, 3'd1, 3'd2});
    if (is_ld) begin
      e_rd = rd;
      case (f)
        3'd0:    e_val = {{24{b[7]}}, b};
        3'd4:    e_val = {24'b0, b};
        3'd1:    e_val = {{16{h[15]}}, h};
        3'd5:    e_val = {16'b0, h};
        default: e_val = word;
      endcase
      exp_q.push_back('{we: 1'b0, addr: wa, src: 32'h0});
    end else if (is_st) begin
      if (f == 3'd2) begin
        exp_q.push_back('{we: 1'b1, addr: wa, src: rs2});
      end else if (ea[17:16] == 2'b11) begin
        exp_q.push_back('{we: 1'b1, addr: wa, src: (f == 3'd0) ? (rs2 & 32'hFF) : (rs2 & 32'hFFFF)});
      end else begin
        merged = word;
        if (f == 3'd0) merged[8*off +: 8] = rs2[7:0];
        else merged[16*(off/2) +: 16] = rs2[15:0];
        exp_q.push_back('{we: 1'b0, addr: wa, src: 32'h0});
        exp_q.push_back('{we: 1'b1, addr: wa, src: merged});
      end
    end
    memop = is_ld || is_st;

    log_q.delete();
    check("vacant_idle", {31'b0, sb_vacant}, 32'd1);
    exe_valid = 1'b1; exe_dest = 1'b1; exe_opt = opt; exe_funct = f;
    exe_rs1 = rs1; exe_imm = imm; exe_rs2 = rs2; exe_rd = rd; exe_pos = pos;
    @(negedge clk);
    check("vacant_busy", {31'b0, sb_vacant}, 32'd0);
    if (memop) begin
      check("mcv_accept1", {31'b0, mc_valid}, 32'd1);
      check("mcwe_first", {31'b0, mc_we}, {31'b0, exp_q[0].we});
      check("mcaddr_first", mc_addr, wa);
    end else begin
      check("unsup_wbv", {31'b0, wb_valid}, 32'd1);
      check("unsup_mcv", {31'b0, mc_valid}, 32'd0);
    end
    if (junk) begin
      exe_pos = ~pos; exe_opt = LOAD; exe_funct = 3'd2; exe_rd = ~rd;
      exe_rs1 = $urandom;
    end else begin
      exe_valid = 1'b0;
    end
    @(negedge clk);
    exe_valid = 1'b0;

    t = 0;
    while (!wb_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!wb_valid) begin
      check("wb_timeout", 32'd0, 32'd1);
      do_reset();
      return;
    end
    if (memop) check("wb_latency", 32'(cyc), 32'(last_done_cyc + 1));
    check("wb_pos", {28'b0, wb_pos}, {28'b0, pos});
    check("wb_rd", {27'b0, wb_rd}, {27'b0, e_rd});
    check("wb_value", wb_value, e_val);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_wbv", {31'b0, wb_valid}, 32'd1);
      check("hold_vacant", {31'b0, sb_vacant}, 32'd0);
      check("hold_pos", {28'b0, wb_pos}, {28'b0, pos});
      check("hold_rd", {27'b0, wb_rd}, {27'b0, e_rd});
      check("hold_value", wb_value, e_val);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    check("wb_drop", {31'b0, wb_valid}, 32'd0);
    check("vacant_after", {31'b0, sb_vacant}, 32'd1);

    check("nreq", 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check("req_we", {31'b0, log_q[i].we}, {31'b0, exp_q[i].we});
      check("req_addr", log_q[i].addr, exp_q[i].addr);
      if (exp_q[i].we) check("req_src", log_q[i].src, exp_q[i].src);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    exe_valid = 1'b0; exe_dest = 1'b0; exe_pos = '0; exe_opt = '0; exe_funct = '0;
    exe_rd = '0; exe_imm = '0; exe_rs1 = '0; exe_rs2 = '0; wb_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_vacant", {31'b0, sb_vacant}, 32'd1);
    check("rst_mcv", {31'b0, mc_valid}, 32'd0);
    check("rst_mcwe", {31'b0, mc_we}, 32'd0);
    check("rst_mcaddr", mc_addr, 32'd0);
    check("rst_mcsrc", mc_src, 32'd0);
    check("rst_wbv", {31'b0, wb_valid}, 32'd0);
    check("rst_wbpos", {28'b0, wb_pos}, 32'd0);
    check("rst_wbrd", {27'b0, wb_rd}, 32'd0);
    check("rst_wbval", wb_value, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Broadcast targeting another unit is ignored.
    exe_valid = 1'b1; exe_dest = 1'b0; exe_opt = LOAD; exe_funct = 3'd2;
    @(negedge clk);
    exe_valid = 1'b0;
    check("dest0_vacant", {31'b0, sb_vacant}, 32'd1);
    check("dest0_mcv", {31'b0, mc_valid}, 32'd0);
    check("dest0_wbv", {31'b0, wb_valid}, 32'd0);

    // Directed cases
    mem[32'h1004] = 32'hDEADBEEF;
    run_op(LOAD, 3'd2, 32'h1000, 32'd4, 32'h0, 5'd7, 4'd3, 0, 1'b0);
    mem[32'h1004] = 32'h80112233;
    run_op(LOAD, 3'd0, 32'h1000, 32'd7, 32'h0, 5'd1, 4'd4, 0, 1'b0);
    run_op(LOAD, 3'd4, 32'h1000, 32'd7, 32'h0, 5'd2, 4'd5, 0, 1'b0);
    run_op(LOAD, 3'd1, 32'h1000, 32'd6, 32'h0, 5'd3, 4'd6, 0, 1'b0);
    mem[32'h2000] = 32'h11223344;
    run_op(STORE, 3'd0, 32'h2000, 32'd1, 32'hAB, 5'd9, 4'd7, 0, 1'b0);
    run_op(STORE, 3'd0, 32'h30000, 32'd0, 32'h41, 5'd9, 4'd8, 0, 1'b0);
    run_op(LOAD, 3'd5, 32'h1000, 32'd3, 32'h0, 5'd12, 4'd9, 5, 1'b0);
    run_op(STORE, 3'd4, 32'h2000, 32'd0, 32'h55, 5'd4, 4'd10, 2, 1'b0);
    run_op(7'b0110011, 3'd0, 32'h2000, 32'd0, 32'h55, 5'd4, 4'd11, 0, 1'b1);

    // Reset while the read half of a read-modify-write is outstanding.
    resp_en = 1'b0;
    exe_valid = 1'b1; exe_dest = 1'b1; exe_opt = STORE; exe_funct = 3'd1;
    exe_rs1 = 32'h2000; exe_imm = 32'd2; exe_rs2 = 32'h7777; exe_rd = 5'd5; exe_pos = 4'd2;
    @(negedge clk);
    exe_valid = 1'b0;
    check("rmw_mcv", {31'b0, mc_valid}, 32'd1);
    check("rmw_mcwe", {31'b0, mc_we}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_vacant", {31'b0, sb_vacant}, 32'd1);
    check("abort_mcv", {31'b0, mc_valid}, 32'd0);
    check("abort_mcwe", {31'b0, mc_we}, 32'd0);
    check("abort_mcaddr", mc_addr, 32'd0);
    check("abort_mcsrc", mc_src, 32'd0);
    check("abort_wbv", {31'b0, wb_valid}, 32'd0);
    stray_req = 1'b1;
    log_q.delete();
    repeat (4) begin
      @(negedge clk);
      check("stray_mcv", {31'b0, mc_valid}, 32'd0);
      check("stray_wbv", {31'b0, wb_valid}, 32'd0);
      check("stray_vacant", {31'b0, sb_vacant}, 32'd1);
    end
    check("stray_nreq", 32'(log_q.size()), 32'd0);
    resp_en = 1'b1;

    // Randomized instructions
    for (int n = 0; n < 250; n++) begin
      int unsigned r;
      bit [6:0] opt;
      r = $urandom_range(0, 9);
      if (r < 5) opt = LOAD;
      else if (r < 9) opt = STORE;
      else opt = 7'($urandom);
      run_op(opt, 3'($urandom), $urandom & 32'h0003_FFFF,
             32'($urandom_range(0, 31)) - 32'd16, $urandom,
             5'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
